// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - two-requester arbiter for the single synchronous dmem port
//
// Shares one data-memory port between the core LSU (port C, priority) and the
// boot/debug loader (port L). A starvation counter forces a loader win after
// MAX_STALL consecutive refusals. Read data returns one cycle after grant and is
// steered by a registered {valid, owner} tag.
//
// Ports:
//   clk, rstN                  clock (rising edge), asynchronous active-low reset
//   cReq/cWe/cAddr/cWData/cSize  core request, held until cGnt
//   cGnt, cRValid, cRData        core grant, load-data valid, load data
//   lReq/lWe/lAddr/lWData/lSize  loader request, held until lGnt
//   lGnt, lRValid, lRData        loader grant, load-data valid, load data
//   memAddr/memWData/memSize     access fields to dmem (from the winner)
//   memWEn, memREn               dmem write / read enables
//   memRData                     dmem read data, registered inside dmem

module dmem_port_arbiter #(
    parameter int unsigned MAX_STALL = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        rstN,

    input  logic        cReq,
    input  logic        cWe,
    input  logic [31:0] cAddr,
    input  logic [31:0] cWData,
    input  logic [2:0]  cSize,
    output logic        cGnt,
    output logic        cRValid,
    output logic [31:0] cRData,

    input  logic        lReq,
    input  logic        lWe,
    input  logic [31:0] lAddr,
    input  logic [31:0] lWData,
    input  logic [2:0]  lSize,
    output logic        lGnt,
    output logic        lRValid,
    output logic [31:0] lRData,

    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [2:0]  memSize,
    output logic        memWEn,
    output logic        memREn,
    input  logic [31:0] memRData
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STALL);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_owner_q, rd_owner_d;   // 1 = loader owns the pending read

    logic l_win;
    logic c_win;
    logic win_we;

    // Arbitration. Everything is gated by rstN so that all grants and enables
    // read as 0 while reset is held, even though the decision is combinational.
    always_comb begin
        l_win  = rstN & lReq & (~cReq | (starve_cnt_q == MAX_CNT));
        c_win  = rstN & cReq & ~l_win;
        win_we = l_win ? lWe : cWe;
    end

    always_comb begin
        cGnt     = c_win;
        lGnt     = l_win;
        // Idle cycles still present the core fields; the enables are what matter.
        memAddr  = rstN ? (l_win ? lAddr  : cAddr)  : 32'h0;
        memWData = rstN ? (l_win ? lWData : cWData) : 32'h0;
        memSize  = rstN ? (l_win ? lSize  : cSize)  : 3'b000;
        memWEn   = (l_win | c_win) & win_we;
        memREn   = (l_win | c_win) & ~win_we;
    end

    // Read return: dmem registers its rData, so data for a read granted in
    // cycle N is on memRData in cycle N+1, exactly when the tag is valid.
    always_comb begin
        cRValid = rd_valid_q & ~rd_owner_q;
        lRValid = rd_valid_q &  rd_owner_q;
        cRData  = rstN ? memRData : 32'h0;
        lRData  = rstN ? memRData : 32'h0;
    end

    always_comb begin
        rd_valid_d = memREn;
        rd_owner_d = l_win;
    end

    // Starvation counter: counts consecutive refused loader cycles, saturating
    // at MAX_CNT; any cycle without lReq or with lGnt restarts the count.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!lReq || l_win) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != MAX_CNT) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            starve_cnt_q <= '0;
            rd_valid_q   <= 1'b0;
            rd_owner_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            rd_valid_q   <= rd_valid_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

endmodule
